// File: rtl/gate_delay_pipe_pkg.sv
// Shared definitions for the gate_delay_pipe block and its combinational gate.
//   OP_W       : width of the operation select
//   gate_op_e  : operation encodings (AND, OR, NAND, NOR, XOR, XNOR, NOT A, pass A)
package gate_delay_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        GATE_AND   = 3'd0,
        GATE_OR    = 3'd1,
        GATE_NAND  = 3'd2,
        GATE_NOR   = 3'd3,
        GATE_XOR   = 3'd4,
        GATE_XNOR  = 3'd5,
        GATE_NOTA  = 3'd6,
        GATE_PASSA = 3'd7
    } gate_op_e;

endpackage

// File: rtl/gate_delay_pipe_alu.sv
// Purely combinational WIDTH-bit bitwise gate, reusable by other logic blocks.
// Ports:
//   a, b : operands
//   op   : operation select (gate_op_e encoding)
//   r    : result
module gate_alu
    import gate_delay_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = '0;
        case (gate_op_e'(op))
            GATE_AND:   r = a & b;
            GATE_OR:    r = a | b;
            GATE_NAND:  r = ~(a & b);
            GATE_NOR:   r = ~(a | b);
            GATE_XOR:   r = a ^ b;
            GATE_XNOR:  r = ~(a ^ b);
            GATE_NOTA:  r = ~a;
            GATE_PASSA: r = a;
            default:    r = '0;
        endcase
    end

endmodule

// File: rtl/gate_delay_pipe.sv
// Bitwise gate whose result is delayed by a programmable 0..MAX_DELAY clocks
// through a free-running {valid, data} shift pipeline (no backpressure).
// Ports:
//   CLK, RST_N     : rising-edge clock, asynchronous active-low reset
//   IN_VALID, A, B : input item and operands
//   OP             : gate operation, captured per item
//   DELAY          : requested latency, clamped to MAX_DELAY; a change while
//                    items are in flight takes effect once the pipe drains
//   FLUSH          : drop every in-flight item and the current input
//   OUT_VALID, X   : delayed result (X is 0 whenever OUT_VALID is 0)
//   BUSY           : at least one item is in flight
module gate_delay_pipe
    import gate_delay_pipe_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MAX_DELAY = 8,
    localparam int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  OP,
    input  logic [DW-1:0]    DELAY,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] X,
    output logic             BUSY
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);

    logic [WIDTH-1:0]              r;
    logic [MAX_DELAY:1]            valid_reg, valid_next, in_window;
    logic [MAX_DELAY:1][WIDTH-1:0] data_reg, data_next;
    logic [DW-1:0]                 dly_reg, delay_clamped, d;
    logic                          accept, busy, sel_valid;
    logic [WIDTH-1:0]              sel_data;

    gate_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (A),
        .b  (B),
        .op (OP),
        .r  (r)
    );

    assign delay_clamped = (DELAY > MAX_D) ? MAX_D : DELAY;
    assign accept        = IN_VALID & ~FLUSH;

    // BUSY only looks at stages 1..dly_reg, so it can be computed from
    // registered state alone; the effective delay then depends on it.
    assign busy = |(valid_reg & in_window);
    assign d    = busy ? dly_reg : delay_clamped;

    genvar gi;
    generate
        for (gi = 1; gi <= MAX_DELAY; gi++) begin : g_stage
            assign in_window[gi] = (DW'(gi) <= dly_reg);
            if (gi == 1) begin : g_first
                // With d = 0 the result is bypassed, so nothing enters.
                assign valid_next[gi] = accept & (d != '0);
                assign data_next[gi]  = r;
            end else begin : g_rest
                // An item leaving stage d is retired rather than shifted on,
                // so no stale valid bit survives beyond the active window
                // to resurface after a later increase of the delay.
                assign valid_next[gi] = valid_reg[gi-1] & ~FLUSH & (DW'(gi - 1) < d);
                assign data_next[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_reg <= '0;
            data_reg  <= '0;
            dly_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            if (!busy) begin
                dly_reg <= d;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        if (d == '0) begin
            sel_valid = accept;
            sel_data  = r;
        end else begin
            for (int i = 1; i <= MAX_DELAY; i++) begin
                if (d == DW'(i)) begin
                    sel_valid = valid_reg[i] & ~FLUSH;
                    sel_data  = data_reg[i];
                end
            end
        end
    end

    // Gating with RST_N keeps the bypass path quiet while reset is held.
    assign OUT_VALID = RST_N & sel_valid;
    assign X         = OUT_VALID ? sel_data : '0;
    assign BUSY      = busy;

endmodule
